// File: rtl/lut_pkg.sv
// Shared LUT definitions: table geometry, writer FSM encoding and the entry type.
// Used by the LUT itself and by its run-time writer.
// No logic here; it holds only types and constants.
package lut_pkg;

  localparam int LUT_ADDR_W = 8;
  localparam int LUT_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } lut_wr_state_t;

  typedef logic [LUT_DATA_W-1:0] lut_word_t;

endpackage

// File: rtl/lut_writer_if.sv
// Byte stream into the LUT writer plus the LUT write port it drives.
// Pure wiring, zero latency.
// byte_ready is the only backpressure signal; the write port has no stall.
interface lut_writer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Byte source and LUT side of the link.
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  // The writer itself.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/lut_writer.sv
// Loads 16-bit LUT entries from a byte stream (high byte first) to sequential addresses from base_addr.
// Latency: wr_en the cycle after the low byte transfers; peak one entry every 3 clocks.
// Backpressure: byte_ready only in HI/LO; a stalled stream holds the FSM indefinitely.
module lut_writer
  import lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DATA_W = LUT_DATA_W   // two stream bytes per entry, so this must stay 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  lut_writer_if.slave       bus,
  output logic              busy,
  output logic              done
);

  lut_wr_state_t     state_q;
  lut_wr_state_t     state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic [7:0]        hi_q;

  // Every output is a flop loaded from the next-state decode, so outputs
  // line up with the state they describe and nothing is combinational
  // from the stream inputs.
  logic              byte_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;

  logic              xfer;

  assign xfer = bus.byte_valid & byte_ready_q;

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign busy           = busy_q;
  assign done           = done_q;

  // Next-state decode for the load sequence.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (start) state_n = (count == '0) ? DONE : HI;
      HI:      if (xfer) state_n = LO;
      LO:      if (xfer) state_n = WRITE;
      WRITE:   state_n = (remain_q == (ADDR_W+1)'(1)) ? DONE : HI;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register plus the address/remaining counters and high-byte holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      hi_q     <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == IDLE && start) begin
        addr_q   <= base_addr;
        remain_q <= count;
      end
      if (state_q == HI && xfer) hi_q <= bus.byte_data;
      if (state_q == WRITE) begin
        addr_q   <= addr_q + ADDR_W'(1);   // wraps at the top of the table
        remain_q <= remain_q - (ADDR_W+1)'(1);
      end
    end
  end

  // Registered Moore outputs; the write word is assembled as the low byte lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      byte_ready_q <= (state_n == HI) || (state_n == LO);
      wr_en_q      <= (state_n == WRITE);
      busy_q       <= (state_n == HI) || (state_n == LO) || (state_n == WRITE);
      done_q       <= (state_n == DONE);
      // Address and data only move on the entry being written; they hold otherwise.
      if (state_q == LO && xfer) begin
        wr_addr_q <= addr_q;
        wr_data_q <= {hi_q, bus.byte_data};
      end
    end
  end

endmodule
